// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RV32 data-memory subsystem: funct3 size codes and FSM states.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and error check on the request side,
// lane extraction and sign/zero extension of the held word on the response side.
module dmem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [1:0]  ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_al,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [3:0]  be_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Request side: lane enables, replicated store data and alignment/encoding error
  always_comb begin
    be_s     = 4'b0000;
    wdata_al = wdata;
    err      = 1'b0;
    case (funct3)
      F3_B: begin
        be_s     = 4'b0001 << addr;
        wdata_al = {4{wdata[7:0]}};
      end
      F3_H: begin
        be_s     = addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata[15:0]}};
        err      = addr[0];
      end
      F3_W: begin
        be_s = 4'b1111;
        err  = (addr != 2'b00);
      end
      F3_BU: err = is_store;
      F3_HU: err = is_store | addr[0];
      default: err = 1'b1;
    endcase
    if (err) begin
      byte_en = 4'b0000;
    end else begin
      byte_en = be_s;
    end
  end

  // Response side: pick the addressed lane of the held word and extend it
  always_comb begin
    case (ld_addr)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = ld_addr[1] ? rword[31:16] : rword[15:0];
    case (ld_funct3)
      F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
      F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
      F3_W:    rdata_ext = rword;
      F3_BU:   rdata_ext = {24'h000000, byte_s};
      F3_HU:   rdata_ext = {16'h0000, half_s};
      default: rdata_ext = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/dmem_unit.sv
// RV32 data memory with byte/half stores, extended loads, alignment errors and a
// configurable response latency behind a request/stall handshake.
module dmem_unit
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqM,
  input  logic        MemWriteM,
  input  logic [31:0] DataAdrM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        RespValidM,
  output logic        StallM,
  output logic        ErrM
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1   = 4'(LATENCY - 1);
  localparam bit         MULTICYC = (LATENCY > 1);

  logic [31:0] mem [DEPTH];

  dmem_state_t state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hold_r;
  logic [1:0]  hold_a_r;
  logic [2:0]  hold_f3_r;
  logic        hold_ld_r;
  logic        pend_err_r;
  logic        resp_valid_r;
  logic        err_r;

  logic [AW-1:0] idx_s;
  logic          accept_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rdata_ext_s;
  logic          err_s;

  assign idx_s    = DataAdrM[AW+1:2];
  assign accept_s = (state_r == IDLE) && ReqM && !reset;

  dmem_lane_align u_align (
    .addr      (DataAdrM[1:0]),
    .funct3    (Funct3M),
    .is_store  (MemWriteM),
    .wdata     (WriteDataM),
    .ld_addr   (hold_a_r),
    .ld_funct3 (hold_f3_r),
    .rword     (hold_r),
    .byte_en   (be_s),
    .wdata_al  (wdata_s),
    .rdata_ext (rdata_ext_s),
    .err       (err_s)
  );

  // Store commit on the acceptance edge; the array is deliberately never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept_s && MemWriteM && be_s[i]) begin
        mem[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

  // Request/response FSM with load hold register and registered response flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      hold_ld_r    <= 1'b0;
      pend_err_r   <= 1'b0;
      resp_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid_r <= 1'b0;
          err_r        <= 1'b0;
          if (accept_s) begin
            cnt_r      <= LAT_M1;
            hold_r     <= mem[idx_s];
            hold_a_r   <= DataAdrM[1:0];
            hold_f3_r  <= Funct3M;
            hold_ld_r  <= !MemWriteM && !err_s;
            pend_err_r <= err_s;
            if (MULTICYC) begin
              state_r <= WAIT;
            end else begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              err_r        <= err_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            err_r        <= pend_err_r;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          err_r        <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          err_r        <= 1'b0;
        end
      endcase
    end
  end

  // Output data is only driven during the response pulse of a good load
  always_comb begin
    if (resp_valid_r && hold_ld_r) begin
      ReadDataM = rdata_ext_s;
    end else begin
      ReadDataM = 32'h00000000;
    end
  end

  assign RespValidM = resp_valid_r;
  assign ErrM       = err_r;
  assign StallM     = ReqM & ~resp_valid_r;

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: one LATENCY=1 and one LATENCY=4 instance, directed accesses.
module tb_dmem_unit;
  import riscv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req [2];
  logic        we  [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [2:0]  f3  [2];
  logic [31:0] rd  [2];
  logic        rv  [2];
  logic        stl [2];
  logic        er  [2];

  dmem_unit #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(rst[0]), .ReqM(req[0]), .MemWriteM(we[0]), .DataAdrM(adr[0]),
    .WriteDataM(wd[0]), .Funct3M(f3[0]), .ReadDataM(rd[0]), .RespValidM(rv[0]),
    .StallM(stl[0]), .ErrM(er[0])
  );

  dmem_unit #(.DEPTH(64), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(rst[1]), .ReqM(req[1]), .MemWriteM(we[1]), .DataAdrM(adr[1]),
    .WriteDataM(wd[1]), .Funct3M(f3[1]), .ReadDataM(rd[1]), .RespValidM(rv[1]),
    .StallM(stl[1]), .ErrM(er[1])
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   sz;
    sz = (d == 0) ? q0.size() : q1.size();
    if (rv[d] === 1'b1) begin
      if (sz == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp dut=%0d actual=resp expected=none", d);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata_d%0d", d), rd[d], e.data);
        chk($sformatf("err_d%0d", d), {31'd0, er[d]}, {31'd0, e.err});
      end
    end else begin
      chk($sformatf("idle_out_d%0d", d), {rd[d][31:1], rd[d][0] | er[d]}, 32'd0);
    end
  endtask

  always @(negedge clk) if (mon_en) mon(0);
  always @(negedge clk) if (mon_en) mon(1);

  task automatic access(input int d, input bit gap, input bit w, input logic [31:0] a,
                        input logic [31:0] data, input logic [2:0] f, input logic [31:0] ed,
                        input bit ee, input string name);
    int   lat;
    int   n;
    int   st;
    exp_t e;
    lat = (d == 0) ? 1 : 4;
    n   = 0;
    st  = 0;
    if (gap) begin
      @(posedge clk); #1;
      chk({name, "_pulse"}, {31'd0, rv[d]}, 32'd0);
    end
    e.data = ed;
    e.err  = ee;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    req[d] = 1'b1; we[d] = w; adr[d] = a; wd[d] = data; f3[d] = f;
    #1;
    if (stl[d] === 1'b1) st++;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rv[d] === 1'b1) break;
      if (stl[d] === 1'b1) st++;
    end
    chk({name, "_lat"}, 32'(n), gap ? 32'(lat) : 32'(lat + 1));
    chk({name, "_stall"}, 32'(st), 32'(lat));
    req[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 32'd0; wd[i] = 32'd0; f3[i] = F3_W;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_rv_d%0d", i), {31'd0, rv[i]}, 32'd0);
      chk($sformatf("reset_err_d%0d", i), {31'd0, er[i]}, 32'd0);
      chk($sformatf("reset_rdata_d%0d", i), rd[i], 32'd0);
    end
    mon_en = 1'b1;

    // LATENCY=1: word, byte and half accesses, error cases, alias wrap
    access(0, 1, 1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0, "sw_dead");
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0, "lw_dead");
    access(0, 1, 1, 32'h10, 32'h11223344, F3_W, 32'h0, 1'b0, "sw_1122");
    access(0, 1, 1, 32'h13, 32'h00000080, F3_B, 32'h0, 1'b0, "sb_80");
    access(0, 1, 0, 32'h13, 32'h0, F3_B, 32'hFFFFFF80, 1'b0, "lb_13");
    access(0, 1, 0, 32'h13, 32'h0, F3_BU, 32'h00000080, 1'b0, "lbu_13");
    access(0, 1, 0, 32'h10, 32'h0, F3_W, 32'h80223344, 1'b0, "lw_10");
    access(0, 1, 1, 32'h20, 32'h00000000, F3_W, 32'h0, 1'b0, "sw_20");
    access(0, 1, 1, 32'h22, 32'h0000BEEF, F3_H, 32'h0, 1'b0, "sh_beef");
    access(0, 1, 0, 32'h22, 32'h0, F3_H, 32'hFFFFBEEF, 1'b0, "lh_22");
    access(0, 1, 0, 32'h22, 32'h0, F3_HU, 32'h0000BEEF, 1'b0, "lhu_22");
    access(0, 1, 0, 32'h21, 32'h0, F3_H, 32'h0, 1'b1, "lh_mis");
    access(0, 1, 1, 32'h21, 32'h00001234, F3_H, 32'h0, 1'b1, "sh_mis");
    access(0, 1, 1, 32'h20, 32'h000000AA, F3_BU, 32'h0, 1'b1, "sbu_ill");
    access(0, 1, 0, 32'h20, 32'h0, F3_W, 32'hBEEF0000, 1'b0, "lw_20");
    access(0, 1, 0, 32'h12, 32'h0, F3_W, 32'h0, 1'b1, "lw_mis");
    access(0, 1, 0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1, "f3_ill");
    access(0, 1, 1, 32'h100, 32'h00000055, F3_W, 32'h0, 1'b0, "sw_alias");
    access(0, 1, 0, 32'h000, 32'h0, F3_W, 32'h00000055, 1'b0, "lw_alias");
    access(0, 0, 0, 32'h10, 32'h0, F3_W, 32'h80223344, 1'b0, "b2b_l1");

    // LATENCY=4: timing, back-to-back request held through the response cycle
    access(1, 1, 1, 32'h08, 32'hCAFEF00D, F3_W, 32'h0, 1'b0, "l4_sw");
    access(1, 1, 0, 32'h08, 32'h0, F3_W, 32'hCAFEF00D, 1'b0, "l4_lw");
    access(1, 0, 0, 32'h0A, 32'h0, F3_HU, 32'h0000CAFE, 1'b0, "l4_b2b");

    // Reset in the middle of a pending load drops it but keeps memory contents
    access(1, 1, 1, 32'h40, 32'h12345678, F3_W, 32'h0, 1'b0, "rst_sw");
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h40; f3[1] = F3_W;
    @(posedge clk); #1;
    chk("rst_in_wait_rv", {31'd0, rv[1]}, 32'd0);
    rst[1] = 1'b1; req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("rst_rv", {31'd0, rv[1]}, 32'd0);
    chk("rst_err", {31'd0, er[1]}, 32'd0);
    chk("rst_stall", {31'd0, stl[1]}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    access(1, 1, 0, 32'h40, 32'h0, F3_W, 32'h12345678, 1'b0, "rst_lw");

    repeat (3) @(posedge clk);
    chk("sb_empty_d0", 32'(q0.size()), 32'd0);
    chk("sb_empty_d1", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
